// File: rtl/ddr_pll_ctrl.sv
// ddr_pll_ctrl: reset/lock sequencer for the DDR rPLL.
// Holds the PLL in reset after power-up, qualifies LOCK through a 2-flop
// synchroniser and a stability window, retries on lock timeout, recovers
// from run-time lock loss and services phase-step requests on PSDA.
// Optional feature macro: DDR_PLL_PSDA_EN (phase stepping + SETTLE state).
// Without it, pll_psda is tied to zero and phase_req is answered with a
// one-cycle phase_ack while ready stays high.
module ddr_pll_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE   = 1024,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned SETTLE_CYCLES = 256
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [3:0] pll_psda,
  output logic [3:0] pll_dutyda,
  input  logic       phase_req,
  input  logic       phase_dir,
  output logic       phase_ack,
  output logic       ready,
  output logic       timeout_err,
  output logic [7:0] relock_cnt
);

  // One shared counter serves the reset pulse and the settle wait.
  localparam int unsigned CMAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  // Terminal values are "last count before the transition", so the
  // transition itself lands on the cycle the count would reach its limit.
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RST_PLL   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_READY     = 2'd2,
    ST_SETTLE    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          lock_meta, lock_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          pll_reset_d, ready_d, ack_d, err_d;
  logic [7:0]    relock_d, relock_inc;

  assign pll_dutyda = 4'b1000;

`ifdef DDR_PLL_PSDA_EN
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES);
  logic [3:0] psda_q, psda_d;
  assign pll_psda = psda_q;
`else
  logic unused_dir;
  assign unused_dir = phase_dir;
  assign pll_psda   = 4'b0000;
`endif

  // Two-flop synchroniser for the asynchronous PLL lock indication.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let lock_s take the old lock_meta,
      // giving two real flop stages; blocking here would collapse them.
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // Next-state, counter and output-next logic for the sequencer.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    stable_d   = stable_q;
    tmo_d      = tmo_q;
    ack_d      = 1'b0;
    err_d      = timeout_err;
    relock_d   = relock_cnt;
    relock_inc = (relock_cnt == 8'hFF) ? relock_cnt : relock_cnt + 8'd1;
`ifdef DDR_PLL_PSDA_EN
    psda_d     = psda_q;
`endif

    case (state_q)
      ST_RST_PLL: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
        else                   cnt_d   = cnt_q + CW'(1);
      end

      ST_WAIT_LOCK: begin
        stable_d = lock_s ? stable_q + SW'(1) : '0;
        tmo_d    = tmo_q + TW'(1);
        // Stability is checked first so a simultaneous timeout loses.
        if (lock_s && (stable_q == STABLE_LAST)) begin
          state_d = ST_READY;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_RST_PLL;
        end
      end

      ST_READY: begin
        // Lock loss outranks a pending step. The ack cycle itself never
        // accepts a request, so a requester dropping phase_req one cycle
        // after the ack does not trigger a second step.
        if (!lock_s) begin
          relock_d = relock_inc;
          state_d  = ST_RST_PLL;
        end else if (phase_req && !phase_ack) begin
`ifdef DDR_PLL_PSDA_EN
          psda_d  = phase_dir ? psda_q + 4'd1 : psda_q - 4'd1;
          state_d = ST_SETTLE;
`else
          ack_d   = 1'b1;
`endif
        end
      end

`ifdef DDR_PLL_PSDA_EN
      ST_SETTLE: begin
        // The stepped code is kept on lock loss; the still-held request
        // is serviced again once READY is regained.
        if (!lock_s) begin
          relock_d = relock_inc;
          state_d  = ST_RST_PLL;
        end else if (cnt_q == SETTLE_LAST) begin
          ack_d   = 1'b1;
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif

      default: state_d = ST_RST_PLL;
    endcase

    // Every counter restarts from zero in the state being entered.
    if (state_d != state_q) begin
      cnt_d    = '0;
      stable_d = '0;
      tmo_d    = '0;
    end

    // Outputs are registered from the next state. ready stays low in the
    // ack cycle that returns from SETTLE.
    pll_reset_d = (state_d == ST_RST_PLL);
    ready_d     = (state_d == ST_READY) && (state_q != ST_SETTLE);
  end

  // State, counter and registered-output flops.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RST_PLL;
      cnt_q       <= '0;
      stable_q    <= '0;
      tmo_q       <= '0;
      pll_reset   <= 1'b1;
      ready       <= 1'b0;
      phase_ack   <= 1'b0;
      timeout_err <= 1'b0;
      relock_cnt  <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stable_q    <= stable_d;
      tmo_q       <= tmo_d;
      pll_reset   <= pll_reset_d;
      ready       <= ready_d;
      phase_ack   <= ack_d;
      timeout_err <= err_d;
      relock_cnt  <= relock_d;
    end
  end

`ifdef DDR_PLL_PSDA_EN
  // Phase code register; only rst_n clears it, never a PLL re-lock.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) psda_q <= 4'd0;
    else        psda_q <= psda_d;
  end
`endif

endmodule

// File: tb/tb_ddr_pll_ctrl.sv
// tb_ddr_pll_ctrl: randomized self-checking bench for ddr_pll_ctrl.
// A behavioural model tracks the sequencer by phase, elapsed cycles in the
// phase and a run length of qualified lock; lock qualification is modelled
// as a delay queue on the driven pll_lock. Outputs are compared every cycle
// 1 time unit after the rising edge, plus directed timing points.
module tb_ddr_pll_ctrl;

  localparam int RST_C = 4;
  localparam int STAB  = 8;
  localparam int TMO   = 32;
  localparam int SETL  = 4;

`ifdef DDR_PLL_PSDA_EN
  localparam bit PSDA_EN = 1'b1;
`else
  localparam bit PSDA_EN = 1'b0;
`endif

  logic       clkin = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       phase_req = 1'b0;
  logic       phase_dir = 1'b0;
  logic       pll_reset;
  logic [3:0] pll_psda;
  logic [3:0] pll_dutyda;
  logic       phase_ack;
  logic       ready;
  logic       timeout_err;
  logic [7:0] relock_cnt;

  always #5 clkin = ~clkin;

  ddr_pll_ctrl #(
    .RST_CYCLES   (RST_C),
    .LOCK_STABLE  (STAB),
    .LOCK_TIMEOUT (TMO),
    .SETTLE_CYCLES(SETL)
  ) dut (
    .clkin      (clkin),
    .rst_n      (rst_n),
    .pll_lock   (pll_lock),
    .pll_reset  (pll_reset),
    .pll_psda   (pll_psda),
    .pll_dutyda (pll_dutyda),
    .phase_req  (phase_req),
    .phase_dir  (phase_dir),
    .phase_ack  (phase_ack),
    .ready      (ready),
    .timeout_err(timeout_err),
    .relock_cnt (relock_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_RST, M_WAIT, M_READY, M_SETTLE} mode_t;
  mode_t m_mode;
  int    m_age;     // rising edges spent in current phase
  int    m_run;     // consecutive qualified-lock edges in WAIT
  int    m_psda;
  int    m_relock;
  bit    m_err;
  bit    m_ack;
  bit    lock_q[$]; // pll_lock history; front = value seen by the next edge
  int    cyc;       // edges since rst_n release
  int    scen;
  int    low_left;

  task automatic model_reset();
    m_mode = M_RST; m_age = 0; m_run = 0; m_psda = 0; m_relock = 0;
    m_err = 1'b0; m_ack = 1'b0;
    lock_q.delete();
    lock_q.push_back(1'b0);
    lock_q.push_back(1'b0);
  endtask

  task automatic enter(input mode_t m);
    m_mode = m; m_age = 0; m_run = 0;
  endtask

  task automatic lose_lock();
    if (m_relock < 255) m_relock++;
    enter(M_RST);
  endtask

  task automatic model_step();
    bit ls;
    bit ack_prev;
    ls       = lock_q.pop_front();
    ack_prev = m_ack;
    m_ack    = 1'b0;
    m_age++;
    case (m_mode)
      M_RST:    if (m_age == RST_C) enter(M_WAIT);
      M_WAIT: begin
        m_run = ls ? m_run + 1 : 0;
        if (m_run == STAB) enter(M_READY);
        else if (m_age == TMO) begin m_err = 1'b1; enter(M_RST); end
      end
      M_READY: begin
        if (!ls) lose_lock();
        else if (phase_req && !ack_prev) begin
          if (PSDA_EN) begin
            m_psda = (m_psda + (phase_dir ? 1 : 15)) % 16;
            enter(M_SETTLE);
          end else begin
            m_ack = 1'b1;
          end
        end
      end
      M_SETTLE: begin
        if (!ls) lose_lock();
        else if (m_age == SETL + 1) begin m_ack = 1'b1; enter(M_READY); end
      end
      default: enter(M_RST);
    endcase
  endtask

  task automatic check_outputs();
    bit exp_ready;
    exp_ready = (m_mode == M_READY) && !(PSDA_EN && m_ack);
    check("pll_reset",   32'(pll_reset),   32'(m_mode == M_RST));
    check("ready",       32'(ready),       32'(exp_ready));
    check("phase_ack",   32'(phase_ack),   32'(m_ack));
    check("pll_psda",    32'(pll_psda),    32'(m_psda));
    check("timeout_err", 32'(timeout_err), 32'(m_err));
    check("relock_cnt",  32'(relock_cnt),  32'(m_relock));
    check("pll_dutyda",  32'(pll_dutyda),  32'd8);
  endtask

  task automatic check_reset();
    check("rst_pll_reset",   32'(pll_reset),   32'd1);
    check("rst_ready",       32'(ready),       32'd0);
    check("rst_phase_ack",   32'(phase_ack),   32'd0);
    check("rst_pll_psda",    32'(pll_psda),    32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_relock_cnt",  32'(relock_cnt),  32'd0);
    check("rst_pll_dutyda",  32'(pll_dutyda),  32'd8);
  endtask

  // Fixed timing points measured from a fresh rst_n release.
  task automatic directed();
    if (scen == 1) begin
      if (cyc == 3)  check("t1_reset_c3",  32'(pll_reset),   32'd1);
      if (cyc == 4)  check("t1_reset_c4",  32'(pll_reset),   32'd0);
      if (cyc == 15) check("t1_ready_c15", 32'(ready),       32'd0);
      if (cyc == 16) check("t1_ready_c16", 32'(ready),       32'd1);
      if (cyc == 16) check("t1_err_c16",   32'(timeout_err), 32'd0);
    end
    if (scen == 2) begin
      if (cyc == 35) check("t2_err_c35",   32'(timeout_err), 32'd0);
      if (cyc == 36) check("t2_err_c36",   32'(timeout_err), 32'd1);
      if (cyc == 39) check("t2_reset_c39", 32'(pll_reset),   32'd1);
      if (cyc == 40) check("t2_reset_c40", 32'(pll_reset),   32'd0);
      if (cyc == 71) check("t2_reset_c71", 32'(pll_reset),   32'd0);
      if (cyc == 72) check("t2_reset_c72", 32'(pll_reset),   32'd1);
    end
  endtask

  // Drive the inputs for the cycle that follows the current edge.
  task automatic drive(input int lock_mode, input int req_pct);
    case (lock_mode)
      0: pll_lock = 1'b0;
      1: pll_lock = 1'b1;
      2: begin
        if (low_left > 0) begin
          pll_lock = 1'b0; low_left--;
        end else if ($urandom_range(0, 39) == 0) begin
          pll_lock = 1'b0; low_left = int'($urandom_range(0, 2));
        end else begin
          pll_lock = 1'b1;
        end
      end
      3: pll_lock = ((cyc % 6) != 0);
      default: pll_lock = (cyc >= 6);
    endcase
    if (phase_req) begin
      // Normally drop after the ack; occasionally hold one more cycle,
      // which the controller must take as a new step.
      if (m_ack) phase_req = ($urandom_range(0, 3) == 0);
    end else if (int'($urandom_range(0, 99)) < req_pct) begin
      phase_req = 1'b1;
      phase_dir = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic run(input int n, input int lock_mode, input int req_pct);
    for (int i = 0; i < n; i++) begin
      @(posedge clkin);
      #1;
      model_step();
      cyc++;
      check_outputs();
      directed();
      drive(lock_mode, req_pct);
      lock_q.push_back(pll_lock);
    end
  endtask

  task automatic release_reset();
    @(negedge clkin);
    model_reset();
    lock_q.push_back(pll_lock);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    #1;
    check_reset();
    repeat (2) @(negedge clkin);
  endtask

  // Run until the controller is mid-step (or ready without stepping),
  // then pull rst_n asynchronously.
  task automatic mid_reset();
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 400 && !hit; k++) begin
      run(1, 1, 60);
      hit = PSDA_EN ? (m_mode == M_SETTLE) : (m_mode == M_READY);
    end
    check("mid_reset_reached", 32'(hit), 32'd1);
    #3;
    assert_reset();
  endtask

  initial begin
    low_left = 0;
    scen     = 0;
    cyc      = 0;
    model_reset();
    repeat (3) @(negedge clkin);
    check_reset();

    // Lock rises at cycle 6 and stays; random steps once ready.
    scen = 1;
    release_reset();
    run(300, 4, 15);

    // Sporadic lock loss with frequent steps.
    scen = 0;
    run(1500, 2, 30);

    // No lock at all: repeated timeouts from a fresh release.
    @(negedge clkin);
    pll_lock  = 1'b0;
    phase_req = 1'b0;
    assert_reset();
    scen = 2;
    release_reset();
    run(120, 0, 20);

    // Lock dropping one cycle in six never qualifies; then steady lock.
    scen = 0;
    run(150, 3, 20);
    run(80, 1, 20);

    // Asynchronous reset in the middle of a step, then recover.
    mid_reset();
    pll_lock = 1'b1;
    release_reset();
    run(200, 1, 25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
